// File: rtl/obstacle_gen.sv
// Per-slot obstacle rectangles for the side-scroller: LFSR-placed spawns at the right
// edge, fixed-step leftward scroll on run frames, retirement count of cleared obstacles.
module obstacle_gen #(
  parameter int          NUM_OBS      = 10,
  parameter int          SCREEN_W     = 640,
  parameter int          OBS_WIDTH    = 40,
  parameter int          OBS_HEIGHT   = 120,
  parameter int          UPPER_BOUND  = 20,
  parameter int          LOWER_BOUND  = 460,
  parameter int          SCROLL_SPEED = 4,
  parameter int          SPAWN_PERIOD = 40,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                gamemode,
  output logic [NUM_OBS-1:0][9:0]   obstacle_x_left,
  output logic [NUM_OBS-1:0][9:0]   obstacle_x_right,
  output logic [NUM_OBS-1:0][8:0]   obstacle_y_up,
  output logic [NUM_OBS-1:0][8:0]   obstacle_y_down,
  output logic [15:0]               obstacles_passed
);

  // mode  | meaning
  // IDLE  | clear slots, counter, lfsr and score
  // RUN   | move/retire, spawn, advance lfsr
  // PAUSE | hold everything
  // CRASH | hold everything
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_PAUSE = 2'b10,
    MODE_CRASH = 2'b11
  } mode_e;

  localparam int Y_SPAN = LOWER_BOUND - UPPER_BOUND - OBS_HEIGHT;
  localparam int CNT_W  = $clog2(SPAWN_PERIOD) + 1;

  localparam logic [9:0]       SPEED_X  = 10'(SCROLL_SPEED);
  localparam logic [9:0]       SPAWN_XL = 10'(SCREEN_W);
  localparam logic [9:0]       SPAWN_XR = 10'(SCREEN_W + OBS_WIDTH);
  localparam logic [8:0]       HEIGHT_Y = 9'(OBS_HEIGHT);
  localparam logic [8:0]       UPPER_Y  = 9'(UPPER_BOUND);
  localparam logic [8:0]       SPAN_Y   = 9'(Y_SPAN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);

  logic [NUM_OBS-1:0] active;
  logic [NUM_OBS-1:0] retire;
  logic [NUM_OBS-1:0] spawn_sel;
  logic               free_found;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;
  logic [CNT_W-1:0]   spawn_cnt;
  logic               spawn_tick;
  logic [15:0]        retire_cnt;
  logic [16:0]        passed_sum;
  logic [15:0]        passed_next;
  logic [8:0]         off;
  logic [8:0]         y_up_new;

  always_comb begin
    lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    spawn_tick = (spawn_cnt == CNT_LAST);

    // Selection looks only at the pre-edge active bits, so a slot retiring now is not reused.
    spawn_sel  = '0;
    free_found = 1'b0;
    retire     = '0;
    retire_cnt = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!active[i] && !free_found && spawn_tick) begin
        spawn_sel[i] = 1'b1;
        free_found   = 1'b1;
      end
      retire[i]  = active[i] && (obstacle_x_right[i] <= SPEED_X);
      retire_cnt = retire_cnt + 16'(retire[i]);
    end

    passed_sum  = {1'b0, obstacles_passed} + {1'b0, retire_cnt};
    passed_next = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];

    off      = (lfsr[8:0] > SPAN_Y) ? (lfsr[8:0] - 9'd256) : lfsr[8:0];
    y_up_new = UPPER_Y + off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active           <= '0;
      obstacle_x_left  <= '0;
      obstacle_x_right <= '0;
      obstacle_y_up    <= '0;
      obstacle_y_down  <= '0;
      obstacles_passed <= '0;
      spawn_cnt        <= '0;
      lfsr             <= SEED;
    end else begin
      case (gamemode)
        MODE_IDLE: begin
          active           <= '0;
          obstacle_x_left  <= '0;
          obstacle_x_right <= '0;
          obstacle_y_up    <= '0;
          obstacle_y_down  <= '0;
          obstacles_passed <= '0;
          spawn_cnt        <= '0;
          lfsr             <= SEED;
        end
        MODE_RUN: begin
          lfsr             <= lfsr_next;
          obstacles_passed <= passed_next;
          spawn_cnt        <= spawn_tick ? '0 : spawn_cnt + CNT_W'(1);
          for (int i = 0; i < NUM_OBS; i++) begin
            if (active[i]) begin
              if (retire[i]) begin
                active[i]           <= 1'b0;
                obstacle_x_left[i]  <= '0;
                obstacle_x_right[i] <= '0;
                obstacle_y_up[i]    <= '0;
                obstacle_y_down[i]  <= '0;
              end else begin
                obstacle_x_right[i] <= obstacle_x_right[i] - SPEED_X;
                obstacle_x_left[i]  <= (obstacle_x_left[i] < SPEED_X) ? 10'd0
                                       : obstacle_x_left[i] - SPEED_X;
              end
            end else if (spawn_sel[i]) begin
              active[i]           <= 1'b1;
              obstacle_x_left[i]  <= SPAWN_XL;
              obstacle_x_right[i] <= SPAWN_XR;
              obstacle_y_up[i]    <= y_up_new;
              obstacle_y_down[i]  <= y_up_new + HEIGHT_Y;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed bench for obstacle_gen: four instances cover default, fast-spawn, full-slot
// and retire/spawn-collision parameterisations.
module tb_obstacle_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] gm_def = 2'b00, gm_p1 = 2'b00, gm_full = 2'b00, gm_col = 2'b00;
  int checks = 0;
  int errors = 0;

  logic [9:0][9:0] def_xl, def_xr, p1_xl, p1_xr, full_xl, full_xr, col_xl, col_xr;
  logic [9:0][8:0] def_yu, def_yd, p1_yu, p1_yd, full_yu, full_yd, col_yu, col_yd;
  logic [15:0]     def_np, p1_np, full_np, col_np;

  always #5 clk = ~clk;

  obstacle_gen u_def (
    .clk(clk), .rst_n(rst_n), .gamemode(gm_def),
    .obstacle_x_left(def_xl), .obstacle_x_right(def_xr),
    .obstacle_y_up(def_yu), .obstacle_y_down(def_yd), .obstacles_passed(def_np));

  obstacle_gen #(.SPAWN_PERIOD(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .gamemode(gm_p1),
    .obstacle_x_left(p1_xl), .obstacle_x_right(p1_xr),
    .obstacle_y_up(p1_yu), .obstacle_y_down(p1_yd), .obstacles_passed(p1_np));

  obstacle_gen #(.SPAWN_PERIOD(1), .SCROLL_SPEED(1)) u_full (
    .clk(clk), .rst_n(rst_n), .gamemode(gm_full),
    .obstacle_x_left(full_xl), .obstacle_x_right(full_xr),
    .obstacle_y_up(full_yu), .obstacle_y_down(full_yd), .obstacles_passed(full_np));

  obstacle_gen #(.SPAWN_PERIOD(1), .SCROLL_SPEED(1), .SCREEN_W(0), .OBS_WIDTH(10)) u_col (
    .clk(clk), .rst_n(rst_n), .gamemode(gm_col),
    .obstacle_x_left(col_xl), .obstacle_x_right(col_xr),
    .obstacle_y_up(col_yu), .obstacle_y_down(col_yd), .obstacles_passed(col_np));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (def_xl[i] !== 10'd0 || def_xr[i] !== 10'd0 || def_yu[i] !== 9'd0 || def_yd[i] !== 9'd0) begin
        errors++;
        $display("FAIL reset_coords slot%0d: got %0d/%0d/%0d/%0d expected 0/0/0/0",
                 i, def_xl[i], def_xr[i], def_yu[i], def_yd[i]);
      end
    end
    checks++;
    if (def_np !== 16'd0) begin
      errors++;
      $display("FAIL reset_passed: got %0d expected 0", def_np);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_first_spawn;
    gm_p1 = 2'b01;
    step(1);
    checks++;
    if (p1_xl[0] !== 10'd640 || p1_xr[0] !== 10'd680 || p1_yu[0] !== 9'd245 || p1_yd[0] !== 9'd365) begin
      errors++;
      $display("FAIL edge1_slot0: got %0d/%0d/%0d/%0d expected 640/680/245/365",
               p1_xl[0], p1_xr[0], p1_yu[0], p1_yd[0]);
    end
    gm_p1 = 2'b10;
    step(3);
    gm_p1 = 2'b11;
    step(2);
    checks++;
    if (p1_xl[0] !== 10'd640 || p1_xl[1] !== 10'd0) begin
      errors++;
      $display("FAIL p1_hold: got slot0 xl %0d slot1 xl %0d expected 640 and 0", p1_xl[0], p1_xl[1]);
    end
    gm_p1 = 2'b01;
    step(1);
    checks++;
    if (p1_xl[0] !== 10'd636 || p1_xr[0] !== 10'd676 || p1_yu[0] !== 9'd245 || p1_yd[0] !== 9'd365) begin
      errors++;
      $display("FAIL edge2_slot0: got %0d/%0d/%0d/%0d expected 636/676/245/365",
               p1_xl[0], p1_xr[0], p1_yu[0], p1_yd[0]);
    end
    checks++;
    if (p1_xl[1] !== 10'd640 || p1_yu[1] !== 9'd132 || p1_yd[1] !== 9'd252) begin
      errors++;
      $display("FAIL edge2_slot1: got xl %0d y %0d/%0d expected 640 132/252", p1_xl[1], p1_yu[1], p1_yd[1]);
    end
    gm_p1 = 2'b00;
    step(1);
  endtask

  task automatic test_lifetime;
    gm_def = 2'b01;
    step(39);
    checks++;
    if (def_xl[0] !== 10'd0) begin
      errors++;
      $display("FAIL early_spawn: edge 39 slot0 xl got %0d expected 0", def_xl[0]);
    end
    step(1);
    checks++;
    if (def_xl[0] !== 10'd640 || def_xr[0] !== 10'd680) begin
      errors++;
      $display("FAIL spawn_edge40: got %0d/%0d expected 640/680", def_xl[0], def_xr[0]);
    end
    step(169);
    checks++;
    if (def_xr[0] !== 10'd4 || def_xl[0] !== 10'd0 || def_np !== 16'd0) begin
      errors++;
      $display("FAIL edge209: got xr %0d xl %0d passed %0d expected 4 0 0", def_xr[0], def_xl[0], def_np);
    end
    step(1);
    checks++;
    if (def_xr[0] !== 10'd0 || def_yu[0] !== 9'd0 || def_np !== 16'd1) begin
      errors++;
      $display("FAIL retire_edge210: got xr %0d yu %0d passed %0d expected 0 0 1", def_xr[0], def_yu[0], def_np);
    end
    step(30);
    checks++;
    if (def_xl[0] !== 10'd640 || def_xl[4] !== 10'd480 || def_xl[5] !== 10'd0 || def_np !== 16'd1) begin
      errors++;
      $display("FAIL reuse_edge240: got s0 %0d s4 %0d s5 %0d passed %0d expected 640 480 0 1",
               def_xl[0], def_xl[4], def_xl[5], def_np);
    end
    gm_def = 2'b00;
    step(1);
    checks++;
    if (def_np !== 16'd0 || def_xl[0] !== 10'd0 || def_xr[4] !== 10'd0) begin
      errors++;
      $display("FAIL idle_clear: got passed %0d s0 xl %0d s4 xr %0d expected 0 0 0", def_np, def_xl[0], def_xr[4]);
    end
  endtask

  task automatic test_pause_hold;
    gm_def = 2'b01;
    step(50);
    checks++;
    if (def_xl[0] !== 10'd600 || def_xr[0] !== 10'd640) begin
      errors++;
      $display("FAIL run50: got %0d/%0d expected 600/640", def_xl[0], def_xr[0]);
    end
    for (int k = 0; k < 25; k++) begin
      gm_def = (k < 20) ? 2'b10 : 2'b11;
      step(1);
      checks++;
      if (def_xl[0] !== 10'd600 || def_xr[0] !== 10'd640 || def_xl[1] !== 10'd0 || def_np !== 16'd0) begin
        errors++;
        $display("FAIL hold_%0d: got s0 %0d/%0d s1 xl %0d passed %0d expected 600/640 0 0",
                 k, def_xl[0], def_xr[0], def_xl[1], def_np);
      end
    end
    gm_def = 2'b01;
    step(1);
    checks++;
    if (def_xl[0] !== 10'd596 || def_xr[0] !== 10'd636) begin
      errors++;
      $display("FAIL resume: got %0d/%0d expected 596/636", def_xl[0], def_xr[0]);
    end
    step(28);
    checks++;
    if (def_xl[1] !== 10'd0) begin
      errors++;
      $display("FAIL resume_no_early: edge 79 slot1 xl got %0d expected 0", def_xl[1]);
    end
    step(1);
    checks++;
    if (def_xl[1] !== 10'd640 || def_xl[0] !== 10'd480) begin
      errors++;
      $display("FAIL resume_spawn80: got s1 %0d s0 %0d expected 640 480", def_xl[1], def_xl[0]);
    end
    gm_def = 2'b00;
    step(1);
  endtask

  task automatic test_slots_full;
    gm_full = 2'b01;
    step(10);
    checks++;
    if (full_xl[9] !== 10'd640 || full_xl[0] !== 10'd631) begin
      errors++;
      $display("FAIL full_edge10: got s9 %0d s0 %0d expected 640 631", full_xl[9], full_xl[0]);
    end
    step(5);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (full_xl[i] !== 10'(626 + i) || full_xr[i] !== 10'(666 + i)) begin
        errors++;
        $display("FAIL full_no_overwrite slot%0d: got %0d/%0d expected %0d/%0d",
                 i, full_xl[i], full_xr[i], 626 + i, 666 + i);
      end
    end
    checks++;
    if (full_yu[0] !== 9'd245 || full_yd[0] !== 9'd365) begin
      errors++;
      $display("FAIL full_slot0_y: got %0d/%0d expected 245/365", full_yu[0], full_yd[0]);
    end
    gm_full = 2'b00;
    step(1);
  endtask

  task automatic test_collision;
    gm_col = 2'b01;
    step(10);
    checks++;
    if (col_xr[0] !== 10'd1 || col_xr[9] !== 10'd10 || col_np !== 16'd0) begin
      errors++;
      $display("FAIL col_edge10: got s0 xr %0d s9 xr %0d passed %0d expected 1 10 0", col_xr[0], col_xr[9], col_np);
    end
    step(1);
    checks++;
    if (col_xr[0] !== 10'd0 || col_yu[0] !== 9'd0 || col_np !== 16'd1) begin
      errors++;
      $display("FAIL col_edge11: got s0 xr %0d yu %0d passed %0d expected 0 0 1", col_xr[0], col_yu[0], col_np);
    end
    step(1);
    checks++;
    if (col_xr[0] !== 10'd10 || col_xr[1] !== 10'd0 || col_np !== 16'd2) begin
      errors++;
      $display("FAIL col_edge12: got s0 xr %0d s1 xr %0d passed %0d expected 10 0 2", col_xr[0], col_xr[1], col_np);
    end
    step(1);
    checks++;
    if (col_xr[0] !== 10'd9 || col_xr[1] !== 10'd10 || col_xr[2] !== 10'd0 || col_np !== 16'd3) begin
      errors++;
      $display("FAIL col_edge13: got s0 %0d s1 %0d s2 %0d passed %0d expected 9 10 0 3",
               col_xr[0], col_xr[1], col_xr[2], col_np);
    end
    gm_col = 2'b00;
    step(1);
    checks++;
    if (col_np !== 16'd0 || col_xr[0] !== 10'd0 || col_xr[1] !== 10'd0 || col_yd[1] !== 9'd0) begin
      errors++;
      $display("FAIL col_idle: got passed %0d s0 xr %0d s1 xr %0d s1 yd %0d expected 0 0 0 0",
               col_np, col_xr[0], col_xr[1], col_yd[1]);
    end
    gm_col = 2'b01;
    step(1);
    checks++;
    if (col_yu[0] !== 9'd245 || col_yd[0] !== 9'd365 || col_xr[0] !== 10'd10) begin
      errors++;
      $display("FAIL col_reseed: got yu %0d yd %0d xr %0d expected 245 365 10", col_yu[0], col_yd[0], col_xr[0]);
    end
    gm_col = 2'b00;
    step(1);
  endtask

  task automatic test_async_reset;
    gm_p1 = 2'b01;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (p1_xl[0] !== 10'd0 || p1_xr[1] !== 10'd0 || p1_yu[2] !== 9'd0 || p1_np !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got s0 xl %0d s1 xr %0d s2 yu %0d passed %0d expected all 0",
               p1_xl[0], p1_xr[1], p1_yu[2], p1_np);
    end
    #1 rst_n = 1'b1;
    step(1);
    checks++;
    if (p1_xl[0] !== 10'd640 || p1_yu[0] !== 9'd245 || p1_yd[0] !== 9'd365 || p1_xl[1] !== 10'd0) begin
      errors++;
      $display("FAIL post_reset_spawn: got xl %0d y %0d/%0d s1 xl %0d expected 640 245/365 0",
               p1_xl[0], p1_yu[0], p1_yd[0], p1_xl[1]);
    end
    gm_p1 = 2'b00;
    step(1);
  endtask

  initial begin
    test_reset;
    test_first_spawn;
    test_lifetime;
    test_pause_hold;
    test_slots_full;
    test_collision;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obstacle_gen.md
# obstacle_gen

Obstacle generator for the frame-clocked side-scroller. It produces the per-slot obstacle rectangles that the game logic block uses for collision detection. Each obstacle enters at the right screen edge with an LFSR-chosen vertical position, scrolls left by a fixed step every running frame, and frees its slot once it has left the screen. It follows the game-logic `gamemode` output (idle / run / pause / crash) and reports a count of obstacles that have cleared the screen.

## Interface
Parameters:
- NUM_OBS, 10: number of obstacle slots.
- SCREEN_W, 640: spawn x_left. Constraint: SCREEN_W+OBS_WIDTH ≤ 1023.
- OBS_WIDTH, 40: obstacle width in px.
- OBS_HEIGHT, 120: obstacle height in px.
- UPPER_BOUND, 20 / LOWER_BOUND, 460: playfield vertical limits.
- SCROLL_SPEED, 4: px moved per running frame (≥1).
- SPAWN_PERIOD, 40: running frames between spawns (≥1).
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  frame clock (60 Hz).
- rst_n  in  1  reset; asynchronous, active-low.
- gamemode  in  2  00 idle, 01 run, 10 pause, 11 crash.
- obstacle_x_left  out  [NUM_OBS-1:0][9:0]  left edge per slot.
- obstacle_x_right  out  [NUM_OBS-1:0][9:0]  right edge per slot.
- obstacle_y_up  out  [NUM_OBS-1:0][8:0]  top edge per slot.
- obstacle_y_down  out  [NUM_OBS-1:0][8:0]  bottom edge per slot.
- obstacles_passed  out  16  count of retired obstacles. Saturates at 16'hFFFF.

## Operation
- Per-slot state: an active bit and four registered coordinates. An inactive slot drives all four coordinates as 0. A zero-width rectangle at x=0 never intersects the player.
- The LFSR is a 16-bit Galois register: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- spawn_cnt is a counter of width clog2(SPAWN_PERIOD)+1.
- Mode 00 (idle):
  - Clear all slots.
  - spawn_cnt←0, lfsr←SEED, obstacles_passed←0.
- Mode 10 / 11 (pause / crash): all state holds.
- Mode 01 (run), on each clk edge:
  1. Move/retire each active slot:
     - If x_right ≤ SCROLL_SPEED: slot goes inactive and obstacles_passed += 1 (saturating). For k slots retiring in the same edge, add k, still saturating.
     - Else: x_right −= SCROLL_SPEED, and x_left ← (x_left < SCROLL_SPEED) ? 0 : x_left − SCROLL_SPEED.
  2. Spawn:
     - If spawn_cnt == SPAWN_PERIOD−1: spawn_cnt←0 and attempt a spawn. Else spawn_cnt+1.
     - A spawn fills the lowest-index slot that was inactive *before* this edge. A slot freed on this edge cannot be reused until the next edge.
     - No free slot: the spawn is dropped silently and the counter still resets.
  3. Spawned coordinates:
     - x_left=SCREEN_W, x_right=SCREEN_W+OBS_WIDTH.
     - off = lfsr[8:0] (current, pre-advance value). If off > Y_SPAN, off −= 256, where Y_SPAN = LOWER_BOUND−UPPER_BOUND−OBS_HEIGHT (must be ≥256).
     - y_up = UPPER_BOUND+off, y_down = y_up+OBS_HEIGHT.
     - A newly spawned slot is not moved on its spawn edge.
  4. lfsr advances once every run edge, whether or not a spawn happens.
- Arithmetic: x is 10-bit unsigned, y is 9-bit unsigned. No subtraction may wrap; the clamping rules above guarantee this.

## Timing
- All outputs are registered and update on the clk rising edge. There is no combinational path from gamemode to the outputs.
- Reset values: all coordinates 0, all slots inactive, obstacles_passed 0, spawn_cnt 0, lfsr SEED.
- Reset is asynchronous. Asserting it mid-run clears everything immediately. After release, operation resumes at the first edge with gamemode 01.
- First spawn: on run edge number SPAWN_PERIOD, counted from idle or reset. Pause edges are not counted.
- Slot lifetime with defaults: 170 run edges after the spawn edge. x_right goes from 680 to 4 in 169 moves, and the slot is freed on the next edge. Peak occupancy is 5 slots.
- A mode change from 01 to 10/11 freezes state on that same edge. Resuming continues from the frozen values with no skipped or duplicated moves.

## Test plan
- Reset then gamemode=01, SPAWN_PERIOD=1, SEED=16'hACE1:
  - After edge 1: slot0 = (640, 680, 245, 365).
  - After edge 2: slot0 = (636, 676, 245, 365) and slot1 y_up=132, y_down=252.
- Defaults, run 40 edges → slot0 appears after edge 40 with x_left=640. Slot0 is active for 170 edges, freed after edge 210, and obstacles_passed=1.
- Pause/crash hold: run 50 edges, hold gamemode=10 for 20 edges, then 11 for 5 → all outputs are unchanged through both holds. Returning to 01 resumes from the exact frozen positions.
- Slots full, SPAWN_PERIOD=1, SCROLL_SPEED=1 → slots 0–9 fill on edges 1–10, edges 11+ drop their spawns, and no slot is overwritten.
- Retire/spawn collision:
  - Setup: SPAWN_PERIOD=1, SCROLL_SPEED=1, NUM_OBS=10, SCREEN_W=0, OBS_WIDTH=10 (slot lifetime 10 edges), so all slots are full and slot0 frees on edge 11.
  - Required response: no slot is spawned on edge 11. Slot0 is refilled on edge 12.
- Mode 00 mid-run, and rst_n pulsed mid-run → all coordinates 0, obstacles_passed 0, and the first spawn again uses SEED (y_up=245 with SPAWN_PERIOD=1).
